video_mixer: RTL and testbench
==============================

VIDEO_MIXER -- requirements
Module: video_mixer

Interface
REQ-001 The block SHALL have parameter COLOUR_BITS, default 6: output bits per colour channel (2..8).
REQ-002 The block SHALL have parameter BAR_SHIFT, default 6: log2 of the testcard bar width in pixels.
REQ-003 The block SHALL have port sysClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports pixelX and pixelY, inputs, 10 bits each: active-area dot and line.
REQ-006 The block SHALL have port displayEnable, input, 1 bit: high inside the active area.
REQ-007 The block SHALL have port vsync, input, 1 bit: regenerated vertical sync, active high.
REQ-008 The block SHALL have ports aiv_red, aiv_green and aiv_blue, inputs, 1 bit each: synchronised AIV RGB111.
REQ-009 The block SHALL have ports pi_red, pi_green and pi_blue, inputs, COLOUR_BITS each: Pi DPI video.
REQ-010 The block SHALL have port mode_req, input, 2 bits: requested mode.
REQ-011 The block SHALL have port mode_valid, input, 1 bit: one-cycle request strobe.
REQ-012 The block SHALL have ports red_out, green_out and blue_out, outputs, COLOUR_BITS each: mixed video.
REQ-013 The block SHALL have port mode_ack, output, 1 bit: one-cycle pulse when a pending mode is applied.
REQ-014 The block SHALL have port current_mode, output, 2 bits: the mode in force.
REQ-015 The block SHALL have port frame_count, output, 8 bits: frame counter.

Function
REQ-016 The block SHALL support modes 0=BLACK, 1=TESTCARD, 2=AIV passthrough and 3=OVERLAY.
REQ-017 The block SHALL detect vsync rising edges using a registered copy of vsync; the edge is the cycle with vsync=1 and the previous value 0.
REQ-018 The block SHALL latch mode_req into a pending register and set pending_flag when mode_valid=1; a later request overwrites the pending value (last wins).
REQ-019 On a vsync edge with pending_flag=1, the block SHALL load current_mode from the pending register, clear pending_flag, and pulse mode_ack high in the next cycle.
REQ-020 A mode_valid in the same cycle as a vsync edge SHALL NOT be applied at that edge; it SHALL stay pending for the following edge.
REQ-021 frame_count SHALL increment on every vsync edge and wrap from 255 to 0.
REQ-022 TESTCARD: with i = pixelX[BAR_SHIFT+2:BAR_SHIFT], the colour SHALL be R=~i[1], G=~i[2], B=~i[0] (white, yellow, cyan, green, magenta, red, blue, black).
REQ-023 1-bit sources SHALL expand to COLOUR_BITS by bit replication (1 -> all ones, 0 -> all zeros).
REQ-024 OVERLAY SHALL output the expanded AIV pixel when any AIV bit is 1; otherwise it SHALL output the Pi pixel (black AIV is transparent).
REQ-025 BLACK SHALL output all zeros; AIV SHALL output the expanded AIV pixel.
REQ-026 The block SHALL have a two-stage pipeline (stage 1 source select, stage 2 expand/border/blank), giving a latency of exactly 2 sysClk cycles from any pixel input to the outputs.
REQ-027 When displayEnable was 0 two cycles earlier, all colour outputs SHALL be 0.

Reset
REQ-028 While nReset=0, all colour outputs, mode_ack, pending_flag, the vsync history, frame_count and current_mode SHALL be 0.
REQ-029 A reset asserted mid-frame or with a request pending SHALL discard the pending request, and no mode_ack SHALL follow.

Configuration
REQ-030 With VIDEO_MIXER_BORDER_EN defined, stage 2 SHALL force white (all ones) where displayEnable=1 and (pixelX==0 or pixelY==0 or the next pixel/line is inactive), regardless of mode, BLACK included.
REQ-031 For the border, next pixel/line inactive SHALL be detected from a one-cycle look-ahead of displayEnable.
REQ-032 Without VIDEO_MIXER_BORDER_EN, the border logic SHALL be absent and outputs SHALL follow REQ-016 to REQ-027 only.

Structure
REQ-033 A shared package SHALL hold the mode enumeration constants (MODE_BLACK..MODE_OVERLAY) and the default COLOUR_BITS.
REQ-034 The block SHALL contain one sub-module, mode_sequencer, holding the request latch, vsync edge detect, mode_ack and frame_count.

Verification
REQ-035 Reset, then mode_valid with mode_req=1 followed by a vsync edge -> mode_ack pulses for 1 cycle; current_mode=1; pixelX=64 (BAR_SHIFT=6) gives yellow 0x3F/0x3F/0x00 two cycles later.
REQ-036 Requests 2 then 3 before one vsync edge -> a single mode_ack; current_mode=3.
REQ-037 mode_valid in the same cycle as a vsync edge -> no ack at that edge; the ack follows the next vsync edge.
REQ-038 OVERLAY with AIV=000 and Pi=0x15/0x2A/0x07 -> output 0x15/0x2A/0x07; with AIV=100 -> output 0x3F/0x00/0x00.
REQ-039 256 vsync edges -> frame_count returns to 0; a reset pulse mid-frame -> all outputs 0, pending request lost.
REQ-040 With VIDEO_MIXER_BORDER_EN defined and mode BLACK -> pixelX=0 in the active area outputs 0x3F on all channels; interior pixels output 0.

Source files
------------

// File: rtl/video_mixer_pkg.sv
// Shared definitions for the video mixer: display modes, default channel depth
// and the testcard bar colour rule.
package video_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_BLACK    = 2'd0,
        MODE_TESTCARD = 2'd1,
        MODE_AIV      = 2'd2,
        MODE_OVERLAY  = 2'd3
    } mode_t;

    localparam int DEFAULT_COLOUR_BITS = 6;

    // Bar index 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black as RGB111
    function automatic logic [2:0] testcardRgb(input logic [2:0] bar);
        return {~bar[1], ~bar[2], ~bar[0]};
    endfunction

endpackage

// File: rtl/mode_sequencer.sv
// Mode request latch, vsync edge detect, mode acknowledge and frame counter.
// Mode changes only take effect on a vsync rising edge so a frame is never torn.
module mode_sequencer
    import video_mixer_pkg::*;
(
    input  logic       sysClk,
    input  logic       nReset,
    input  logic       vsync,
    input  logic [1:0] modeReq,
    input  logic       modeValid,
    output mode_t      currentMode,
    output logic       modeAck,
    output logic [7:0] frameCount
);

    logic  vsyncPrev;
    logic  pendingFlag;
    mode_t pendingMode;
    logic  vsyncEdge;

    assign vsyncEdge = vsync & ~vsyncPrev;

    // A request arriving on the edge cycle is written after the apply, so it waits for the next edge
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            vsyncPrev   <= 1'b0;
            pendingFlag <= 1'b0;
            pendingMode <= MODE_BLACK;
            currentMode <= MODE_BLACK;
            modeAck     <= 1'b0;
            frameCount  <= 8'd0;
        end else begin
            vsyncPrev <= vsync;
            modeAck   <= vsyncEdge & pendingFlag;
            if (vsyncEdge) begin
                frameCount <= frameCount + 8'd1;
            end
            if (vsyncEdge && pendingFlag) begin
                currentMode <= pendingMode;
                pendingFlag <= 1'b0;
            end
            if (modeValid) begin
                pendingMode <= mode_t'(modeReq);
                pendingFlag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mixer.sv
// Video mixer: black / testcard / AIV passthrough / overlay, two-stage pipeline.
// Define VIDEO_MIXER_BORDER_EN to draw a white frame around the active area.
module video_mixer
    import video_mixer_pkg::*;
#(
    parameter int COLOUR_BITS = DEFAULT_COLOUR_BITS,
    parameter int BAR_SHIFT   = 6
) (
    input  logic                   sysClk,
    input  logic                   nReset,
    input  logic [9:0]             pixelX,
    input  logic [9:0]             pixelY,
    input  logic                   displayEnable,
    input  logic                   vsync,
    input  logic                   aiv_red,
    input  logic                   aiv_green,
    input  logic                   aiv_blue,
    input  logic [COLOUR_BITS-1:0] pi_red,
    input  logic [COLOUR_BITS-1:0] pi_green,
    input  logic [COLOUR_BITS-1:0] pi_blue,
    input  logic [1:0]             mode_req,
    input  logic                   mode_valid,
    output logic [COLOUR_BITS-1:0] red_out,
    output logic [COLOUR_BITS-1:0] green_out,
    output logic [COLOUR_BITS-1:0] blue_out,
    output logic                   mode_ack,
    output logic [1:0]             current_mode,
    output logic [7:0]             frame_count
);

    localparam int PW = 3 * COLOUR_BITS;

    mode_t currentMode;

    mode_sequencer sequencer (
        .sysClk     (sysClk),
        .nReset     (nReset),
        .vsync      (vsync),
        .modeReq    (mode_req),
        .modeValid  (mode_valid),
        .currentMode(currentMode),
        .modeAck    (mode_ack),
        .frameCount (frame_count)
    );

    assign current_mode = currentMode;

    logic [2:0]    aivRgb;
    logic [2:0]    nextRgb;
    logic          nextUsePi;
    logic          s1En;
    logic [2:0]    s1Rgb;
    logic          s1UsePi;
    logic [PW-1:0] s1Pi;
    logic [PW-1:0] mixPixel;
    logic [PW-1:0] outPixel;

    assign aivRgb = {aiv_red, aiv_green, aiv_blue};

    always_comb begin
        nextRgb   = 3'b000;
        nextUsePi = 1'b0;
        case (currentMode)
            MODE_TESTCARD: nextRgb = testcardRgb(pixelX[BAR_SHIFT+2:BAR_SHIFT]);
            MODE_AIV:      nextRgb = aivRgb;
            MODE_OVERLAY: begin
                if (|aivRgb) begin
                    nextRgb = aivRgb;
                end else begin
                    nextUsePi = 1'b1;
                end
            end
            default:       nextRgb = 3'b000;
        endcase
    end

`ifdef VIDEO_MIXER_BORDER_EN
    logic s1Edge;

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            s1Edge <= 1'b0;
        end else begin
            s1Edge <= (pixelX == 10'd0) || (pixelY == 10'd0);
        end
    end
`else
    logic unusedPins;
    assign unusedPins = ^{pixelX, pixelY};
`endif

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            s1En    <= 1'b0;
            s1Rgb   <= 3'b000;
            s1UsePi <= 1'b0;
            s1Pi    <= '0;
        end else begin
            s1En    <= displayEnable;
            s1Rgb   <= nextRgb;
            s1UsePi <= nextUsePi;
            s1Pi    <= {pi_red, pi_green, pi_blue};
        end
    end

    // The live displayEnable is one pixel ahead of stage 1, giving the right/last-pixel border edge
    always_comb begin
        mixPixel = s1UsePi ? s1Pi
                           : {{COLOUR_BITS{s1Rgb[2]}}, {COLOUR_BITS{s1Rgb[1]}}, {COLOUR_BITS{s1Rgb[0]}}};
        if (!s1En) begin
            mixPixel = '0;
        end
`ifdef VIDEO_MIXER_BORDER_EN
        if (s1En && (s1Edge || !displayEnable)) begin
            mixPixel = '1;
        end
`endif
    end

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            outPixel <= '0;
        end else begin
            outPixel <= mixPixel;
        end
    end

    assign red_out   = outPixel[PW-1 -: COLOUR_BITS];
    assign green_out = outPixel[2*COLOUR_BITS-1 -: COLOUR_BITS];
    assign blue_out  = outPixel[COLOUR_BITS-1:0];

endmodule

// File: tb/tb_video_mixer.sv
// Self-checking bench for video_mixer: directed scenarios plus randomized traffic
// against a frame-level behavioural model.
module tb_video_mixer;

    localparam int CB = 6;
    localparam int BS = 6;
    localparam int PW = 3 * CB;

    logic          sysClk = 1'b0;
    logic          nReset;
    logic [9:0]    pixelX, pixelY;
    logic          displayEnable, vsync;
    logic          aiv_red, aiv_green, aiv_blue;
    logic [CB-1:0] pi_red, pi_green, pi_blue;
    logic [1:0]    mode_req;
    logic          mode_valid;
    logic [CB-1:0] red_out, green_out, blue_out;
    logic          mode_ack;
    logic [1:0]    current_mode;
    logic [7:0]    frame_count;

    video_mixer #(.COLOUR_BITS(CB), .BAR_SHIFT(BS)) dut (
        .sysClk(sysClk), .nReset(nReset), .pixelX(pixelX), .pixelY(pixelY),
        .displayEnable(displayEnable), .vsync(vsync),
        .aiv_red(aiv_red), .aiv_green(aiv_green), .aiv_blue(aiv_blue),
        .pi_red(pi_red), .pi_green(pi_green), .pi_blue(pi_blue),
        .mode_req(mode_req), .mode_valid(mode_valid),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .mode_ack(mode_ack), .current_mode(current_mode), .frame_count(frame_count)
    );

    always #5 sysClk = ~sysClk;

    typedef struct packed {
        logic          en;
        logic [9:0]    x;
        logic [9:0]    y;
        logic [2:0]    aiv;
        logic [PW-1:0] pi;
        logic [1:0]    mode;
    } rec_t;

    int vectors = 0;
    int miscompares = 0;
    int dutAcks = 0;

    // Model state
    int            mCur, mPend, mFrame;
    bit            mPendFlag, mVprev, mAck;
    rec_t          prevRec;
    logic [PW-1:0] expPixel;

    function automatic logic [2:0] barColour(int bar);
        case (bar)
            0: return 3'b111;  // white
            1: return 3'b110;  // yellow
            2: return 3'b011;  // cyan
            3: return 3'b010;  // green
            4: return 3'b101;  // magenta
            5: return 3'b100;  // red
            6: return 3'b001;  // blue
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [PW-1:0] expand3(logic [2:0] rgb);
        logic [PW-1:0] p;
        p = '0;
        for (int c = 0; c < 3; c++)
            if (rgb[c]) p = p | (((PW)'(1) << CB) - 1) << (c * CB);
        return p;
    endfunction

    function automatic logic [PW-1:0] pixelFor(rec_t r, logic nextEn);
        int bar;
        bar = (int'(r.x) / (1 << BS)) % 8;
        if (!r.en) return '0;
`ifdef VIDEO_MIXER_BORDER_EN
        if (r.x == 0 || r.y == 0 || !nextEn) return '1;
`else
        if (nextEn === 1'bx) return '0;
`endif
        case (r.mode)
            2'd0: return '0;
            2'd1: return expand3(barColour(bar));
            2'd2: return expand3(r.aiv);
            default: return (r.aiv != 3'b000) ? expand3(r.aiv) : r.pi;
        endcase
    endfunction

    task automatic checkValue(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        if (mode_ack === 1'b1) dutAcks++;
        checkValue("pixel", 32'({red_out, green_out, blue_out}), 32'(expPixel));
        checkValue("mode_ack", 32'(mode_ack), 32'(mAck));
        checkValue("current_mode", 32'(current_mode), 32'(mCur));
        checkValue("frame_count", 32'(frame_count), 32'(mFrame));
    endtask

    // Advance the model by one clock from the inputs currently driven, then check after the edge
    task automatic stepCycle();
        rec_t cur;
        bit   vsEdge;
        cur.en = displayEnable; cur.x = pixelX; cur.y = pixelY;
        cur.aiv = {aiv_red, aiv_green, aiv_blue};
        cur.pi = {pi_red, pi_green, pi_blue};
        cur.mode = 2'(mCur);
        if (!nReset) begin
            mCur = 0; mPend = 0; mFrame = 0;
            mPendFlag = 0; mVprev = 0; mAck = 0;
            prevRec = '0; expPixel = '0;
        end else begin
            expPixel = pixelFor(prevRec, displayEnable);
            prevRec = cur;
            vsEdge = vsync && !mVprev;
            mAck = vsEdge && mPendFlag;
            if (mAck) begin mCur = mPend; mPendFlag = 0; end
            if (vsEdge) mFrame = (mFrame + 1) % 256;
            if (mode_valid) begin mPend = int'(mode_req); mPendFlag = 1; end
            mVprev = vsync;
        end
        @(posedge sysClk);
        @(negedge sysClk);
        checkOutput();
    endtask

    task automatic setPixel(logic en, int x, int y, logic [2:0] aiv, logic [PW-1:0] pi);
        displayEnable = en; pixelX = 10'(x); pixelY = 10'(y);
        {aiv_red, aiv_green, aiv_blue} = aiv;
        {pi_red, pi_green, pi_blue} = pi;
    endtask

    task automatic applyStimulus(logic vs, logic valid, logic [1:0] req);
        vsync = vs; mode_valid = valid; mode_req = req;
        stepCycle();
        mode_valid = 1'b0;
    endtask

    task automatic vsyncPulse();
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
    endtask

    task automatic doReset();
        nReset = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        nReset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        int acksBefore;
        nReset = 1'b0;
        setPixel(1'b0, 0, 0, 3'b000, '0);
        vsync = 1'b0; mode_valid = 1'b0; mode_req = 2'd0;
        @(negedge sysClk);

        // Reset state
        nReset = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("reset red", 32'(red_out), 0);
        checkValue("reset ack", 32'(mode_ack), 0);
        checkValue("reset mode", 32'(current_mode), 0);
        checkValue("reset frame", 32'(frame_count), 0);
        nReset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0);

        // Testcard request, ack pulse and yellow bar
        applyStimulus(1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkValue("ack pulse", 32'(mode_ack), 1);
        checkValue("mode testcard", 32'(current_mode), 1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("ack one cycle", 32'(mode_ack), 0);
        setPixel(1'b1, 64, 10, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        setPixel(1'b1, 65, 10, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("yellow red", 32'(red_out), 'h3F);
        checkValue("yellow green", 32'(green_out), 'h3F);
        checkValue("yellow blue", 32'(blue_out), 'h00);

        // Last request wins, single ack
        acksBefore = dutAcks;
        applyStimulus(1'b0, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b1, 2'd3);
        vsyncPulse();
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("single ack", 32'(dutAcks - acksBefore), 1);
        checkValue("mode overlay", 32'(current_mode), 3);

        // Request coincident with the edge waits for the next edge
        applyStimulus(1'b1, 1'b1, 2'd1);
        checkValue("no ack same edge", 32'(mode_ack), 0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkValue("ack next edge", 32'(mode_ack), 1);
        checkValue("mode after next edge", 32'(current_mode), 1);
        applyStimulus(1'b0, 1'b0, 2'd0);

        // Overlay transparency
        applyStimulus(1'b0, 1'b1, 2'd3);
        vsyncPulse();
        setPixel(1'b1, 100, 50, 3'b000, {6'h15, 6'h2A, 6'h07});
        applyStimulus(1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("overlay pi", 32'({red_out, green_out, blue_out}), 32'({6'h15, 6'h2A, 6'h07}));
        setPixel(1'b1, 100, 50, 3'b100, {6'h15, 6'h2A, 6'h07});
        applyStimulus(1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("overlay aiv", 32'({red_out, green_out, blue_out}), 32'({6'h3F, 6'h00, 6'h00}));

`ifdef VIDEO_MIXER_BORDER_EN
        applyStimulus(1'b0, 1'b1, 2'd0);
        vsyncPulse();
        setPixel(1'b1, 0, 5, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        setPixel(1'b1, 1, 5, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("border left", 32'({red_out, green_out, blue_out}), 32'({PW{1'b1}}));
        setPixel(1'b1, 2, 5, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("border interior", 32'({red_out, green_out, blue_out}), 0);
`endif

        // Frame counter wrap
        setPixel(1'b0, 0, 0, 3'b000, '0);
        doReset();
        for (int i = 0; i < 256; i++) vsyncPulse();
        checkValue("frame wrap", 32'(frame_count), 0);

        // Reset mid-frame discards a pending request
        setPixel(1'b1, 300, 200, 3'b111, '1);
        applyStimulus(1'b0, 1'b1, 2'd2);
        nReset = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("reset pixel", 32'({red_out, green_out, blue_out}), 0);
        nReset = 1'b1;
        acksBefore = dutAcks;
        vsyncPulse();
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkValue("pending lost ack", 32'(dutAcks - acksBefore), 0);
        checkValue("pending lost mode", 32'(current_mode), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            setPixel($urandom_range(0, 9) != 0, $urandom_range(0, 639), $urandom_range(0, 479),
                     3'($urandom), PW'($urandom));
            if ($urandom_range(0, 19) == 0) pixelX = 10'd0;
            nReset = ($urandom_range(0, 499) != 0);
            applyStimulus(($urandom_range(0, 7) == 0) ? ~vsync : vsync,
                          $urandom_range(0, 9) == 0, 2'($urandom));
        end
        nReset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
